// File: rtl/vnu_serial_param.sv
// Serial LDPC variable node: takes DEGREE check messages plus the channel LLR, then emits DEGREE extrinsics.
// Optional macro VNU_SAT_EN: symmetric saturation of out_msg; otherwise out_msg wraps to OUT_W bits.
module vnu_serial_param #(
  parameter  int DEGREE = 3,
  parameter  int MSG_W  = 5,
  parameter  int LLR_W  = 5,
  parameter  int OUT_W  = 6,
  localparam int SUM_W  = ((MSG_W > LLR_W) ? MSG_W : LLR_W) + $clog2(DEGREE + 1),
  localparam int IDX_W  = $clog2(DEGREE)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MSG_W-1:0] in_msg,
  input  logic [LLR_W-1:0] in_llr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_msg,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             hard_decision
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] EMIT  = 2'd2;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEGREE - 1);

  logic [1:0]                   state;
  logic [IDX_W-1:0]             count;
  logic [IDX_W-1:0]             idx;
  logic [SUM_W-1:0]             total;
  logic [DEGREE-1:0][MSG_W-1:0] msg_buf;
  logic                         hd;

  logic                    accept, take;
  logic [SUM_W-1:0]        msg_ext, llr_ext, total_nxt, buf_ext;
  logic signed [SUM_W-1:0] diff;
  logic signed [31:0]      diff_w;
  logic [OUT_W-1:0]        ext_val;

  assign in_ready  = (state != EMIT);
  assign out_valid = (state == EMIT);
  assign accept    = in_valid && in_ready;
  assign take      = out_valid && out_ready;

  assign msg_ext   = {{(SUM_W-MSG_W){in_msg[MSG_W-1]}}, in_msg};
  assign llr_ext   = {{(SUM_W-LLR_W){in_llr[LLR_W-1]}}, in_llr};
  // The first beat of a frame seeds the sum with the channel LLR.
  assign total_nxt = (state == IDLE) ? (llr_ext + msg_ext) : (total + msg_ext);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      count   <= '0;
      idx     <= '0;
      total   <= '0;
      msg_buf <= '0;
      hd      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          total      <= total_nxt;
          msg_buf[0] <= in_msg;
          count      <= IDX_W'(1);
          state      <= ACCUM;
        end
        ACCUM: if (accept) begin
          total          <= total_nxt;
          msg_buf[count] <= in_msg;
          if (count == LAST) begin
            count <= '0;
            idx   <= '0;
            hd    <= total_nxt[SUM_W-1];
            state <= EMIT;
          end else begin
            count <= count + IDX_W'(1);
          end
        end
        EMIT: if (take) begin
          if (idx == LAST) begin
            idx   <= '0;
            state <= IDLE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign buf_ext = {{(SUM_W-MSG_W){msg_buf[idx][MSG_W-1]}}, msg_buf[idx]};
  assign diff    = total - buf_ext;
  assign diff_w  = 32'(diff);

`ifdef VNU_SAT_EN
  localparam logic signed [31:0] SAT_MAX = (32'sd1 <<< (OUT_W - 1)) - 32'sd1;
  localparam logic signed [31:0] SAT_MIN = -SAT_MAX;

  // Clamp is symmetric so the most negative code never appears on out_msg.
  always_comb begin
    ext_val = OUT_W'(diff_w);
    if (diff_w > SAT_MAX)      ext_val = OUT_W'(SAT_MAX);
    else if (diff_w < SAT_MIN) ext_val = OUT_W'(SAT_MIN);
  end
`else
  assign ext_val = OUT_W'(diff_w);
`endif

  assign out_msg       = out_valid ? ext_val : '0;
  assign out_idx       = idx;
  assign out_last      = out_valid && (idx == LAST);
  assign hard_decision = hd;
endmodule
